timer_input_controller: RTL and testbench

Input-side counterpart of the buzzer, light and display controllers in `main`. It synchronises and debounces the push buttons, loads and edits a seconds count from `dipSwitch` and the buttons, and runs the countdown FSM. The `state` and `count` it produces are the values the output controllers decode. It sits between the board inputs and those three controllers.

---
 rtl/timer_input_controller.sv | 215 +++++++++++++++++++++
 tb/tb_timer_input_controller.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/timer_input_controller.sv
// Countdown timer front end: debounces the five push buttons, edits the seconds count and runs
// the IDLE/RUN/PAUSE/ALARM FSM. Define TIMER_ALARM_TIMEOUT_EN to auto-clear ALARM.
module timer_input_controller #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned TICK_CYCLES     = 50000000,
  parameter int unsigned ALARM_SECONDS   = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sw2,
  input  logic       sw3,
  input  logic       sw4,
  input  logic       sw5,
  input  logic       sw6,
  input  logic [9:0] dipSwitch,
  output logic [2:0] state,
  output logic [9:0] count,
  output logic       tick
);

  localparam int unsigned NumBtn   = 5;
  localparam int unsigned DbW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned PsW      = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [9:0]  MaxCount = 10'd999;

  if (DEBOUNCE_CYCLES < 1 || TICK_CYCLES < 2 || ALARM_SECONDS < 1) begin : g_bad_param
    $error("timer_input_controller: parameters out of range");
  end

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StRun   = 3'd1,
    StPause = 3'd2,
    StAlarm = 3'd3
  } state_e;

  // Button index: 0=sw2 start, 1=sw3 load, 2=sw4 clear, 3=sw5 inc, 4=sw6 dec.
  logic [NumBtn-1:0] btn_raw;
  logic [NumBtn-1:0] sync1_q, sync1_d;
  logic [NumBtn-1:0] sync2_q, sync2_d;
  logic [NumBtn-1:0] level_q, level_d;
  logic [NumBtn-1:0] press_q, press_d;
  logic [DbW-1:0]    db_cnt_q [NumBtn];
  logic [DbW-1:0]    db_cnt_d [NumBtn];

  assign btn_raw = {sw6, sw5, sw4, sw3, sw2};

  // A level is accepted only once the counter has seen the full run of differing samples.
  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    level_d = level_q;
    press_d = '0;
    for (int i = 0; i < NumBtn; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != level_q[i]) begin
        if (db_cnt_q[i] == DbW'(DEBOUNCE_CYCLES)) begin
          level_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DbW'(1);
        end
      end
      press_d[i] = level_q[i] & ~level_d[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '1;
      sync2_q <= '1;
      level_q <= '1;
      press_q <= '0;
      for (int i = 0; i < NumBtn; i++) begin
        db_cnt_q[i] <= '0;
      end
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      press_q <= press_d;
      for (int i = 0; i < NumBtn; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
    end
  end

  logic p_start, p_load, p_clear, p_inc, p_dec;
  assign p_start = press_q[0];
  assign p_load  = press_q[1];
  assign p_clear = press_q[2];
  assign p_inc   = press_q[3];
  assign p_dec   = press_q[4];

  state_e         state_q, state_d;
  logic [9:0]     count_q, count_d;
  logic           tick_q, tick_d;
  logic [PsW-1:0] presc_q, presc_d;
  logic           presc_term;

  assign presc_term = (presc_q == PsW'(TICK_CYCLES - 1));

`ifdef TIMER_ALARM_TIMEOUT_EN
  localparam int unsigned AsW = $clog2(ALARM_SECONDS + 1);
  logic [AsW-1:0] alarm_cnt_q, alarm_cnt_d;
`endif

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    tick_d  = 1'b0;
    presc_d = presc_q;
`ifdef TIMER_ALARM_TIMEOUT_EN
    alarm_cnt_d = '0;
`endif
    unique case (state_q)
      StIdle: begin
        presc_d = '0;
        if (p_start && count_q != 10'd0) begin
          state_d = StRun;
        end else if (p_load) begin
          count_d = (dipSwitch > MaxCount) ? MaxCount : dipSwitch;
        end else if (p_inc) begin
          if (count_q != MaxCount) count_d = count_q + 10'd1;
        end else if (p_dec) begin
          if (count_q != 10'd0) count_d = count_q - 10'd1;
        end
      end
      StRun: begin
        if (p_clear) begin
          state_d = StIdle;
          count_d = '0;
          presc_d = '0;
        end else if (presc_term) begin
          tick_d  = 1'b1;
          count_d = count_q - 10'd1;
          presc_d = '0;
          if (count_q == 10'd1) begin
            state_d = StAlarm;
          end else if (p_start) begin
            state_d = StPause;
          end
        end else begin
          presc_d = presc_q + PsW'(1);
          if (p_start) state_d = StPause;
        end
      end
      StPause: begin
        if (p_clear) begin
          state_d = StIdle;
          count_d = '0;
          presc_d = '0;
        end else if (p_start) begin
          state_d = StRun;
        end
      end
      StAlarm: begin
        count_d = '0;
        if (p_start || p_clear) begin
          state_d = StIdle;
          presc_d = '0;
        end else begin
`ifdef TIMER_ALARM_TIMEOUT_EN
          alarm_cnt_d = alarm_cnt_q;
          if (presc_term) begin
            presc_d = '0;
            if (alarm_cnt_q == AsW'(ALARM_SECONDS - 1)) begin
              state_d = StIdle;
            end else begin
              alarm_cnt_d = alarm_cnt_q + AsW'(1);
            end
          end else begin
            presc_d = presc_q + PsW'(1);
          end
`else
          presc_d = '0;
`endif
        end
      end
      default: begin
        state_d = StIdle;
        count_d = '0;
        presc_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      count_q <= '0;
      tick_q  <= 1'b0;
      presc_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      tick_q  <= tick_d;
      presc_q <= presc_d;
    end
  end

`ifdef TIMER_ALARM_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      alarm_cnt_q <= '0;
    end else begin
      alarm_cnt_q <= alarm_cnt_d;
    end
  end
`endif

  assign state = state_q;
  assign count = count_q;
  assign tick  = tick_q;

endmodule

// File: tb/tb_timer_input_controller.sv
// Directed bench for timer_input_controller with DEBOUNCE_CYCLES=4 and TICK_CYCLES=8.
// A press driven just after edge k acts on state/count at edge k+8.
module tb_timer_input_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] btn = 5'h1F;  // 0=sw2 1=sw3 2=sw4 3=sw5 4=sw6
  logic [9:0] dip = 10'd0;
  logic [2:0] state;
  logic [9:0] count;
  logic       tick;

  int n_tests = 0;
  int n_fail  = 0;

  timer_input_controller #(
    .DEBOUNCE_CYCLES(4),
    .TICK_CYCLES    (8),
    .ALARM_SECONDS  (10)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sw2      (btn[0]),
    .sw3      (btn[1]),
    .sw4      (btn[2]),
    .sw5      (btn[3]),
    .sw6      (btn[4]),
    .dipSwitch(dip),
    .state    (state),
    .count    (count),
    .tick     (tick)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Settle the previous release, press, and return right after the acting edge.
  task automatic press_btn(input int idx);
    cyc(7);
    btn[idx] = 1'b0;
    cyc(8);
    btn[idx] = 1'b1;
  endtask

  initial begin
    cyc(2);
    check("rst_state", 32'(state), 0);
    check("rst_count", 32'(count), 0);
    check("rst_tick", 32'(tick), 0);
    rst = 1'b0;

    // Load with saturation, including exact latency.
    dip = 10'd1023;
    cyc(7);
    btn[1] = 1'b0;
    cyc(7);
    check("load_before_edge", 32'(count), 0);
    cyc(1);
    btn[1] = 1'b1;
    check("load_sat", 32'(count), 999);
    press_btn(3);
    check("inc_sat", 32'(count), 999);
    press_btn(4);
    check("dec", 32'(count), 998);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    check("rst_clears_count", 32'(count), 0);
    press_btn(4);
    check("dec_sat", 32'(count), 0);

    // Bounce rejection: five 3-cycle glitches, then a real press.
    cyc(7);
    for (int i = 0; i < 5; i++) begin
      btn[3] = 1'b0;
      cyc(3);
      btn[3] = 1'b1;
      cyc(3);
    end
    check("bounce_no_event", 32'(count), 0);
    btn[3] = 1'b0;
    cyc(7);
    check("held_edge6", 32'(count), 0);
    cyc(1);
    check("held_edge7", 32'(count), 1);
    cyc(3);
    btn[3] = 1'b1;
    cyc(7);
    check("single_inc", 32'(count), 1);

    // Countdown from 3 into ALARM.
    dip = 10'd3;
    press_btn(1);
    check("load3", 32'(count), 3);
    press_btn(0);
    check("start_run", 32'(state), 1);
    cyc(7);
    check("no_tick_early", 32'(tick), 0);
    check("count_hold", 32'(count), 3);
    cyc(1);
    check("tick1", 32'(tick), 1);
    check("tick1_count", 32'(count), 2);
    cyc(1);
    check("tick_pulse_1cyc", 32'(tick), 0);
    cyc(7);
    check("tick2", 32'(tick), 1);
    check("tick2_count", 32'(count), 1);
    cyc(8);
    check("tick3", 32'(tick), 1);
    check("tick3_count", 32'(count), 0);
    check("alarm", 32'(state), 3);
    cyc(20);
    check("alarm_holds", 32'(state), 3);
    press_btn(0);
    check("ack_idle", 32'(state), 0);

    // Pause 3 cycles after a tick, resume, next tick 5 cycles later.
    dip = 10'd5;
    press_btn(1);
    press_btn(0);
    cyc(4);
    press_btn(0);
    check("pause_state", 32'(state), 2);
    check("pause_count", 32'(count), 3);
    cyc(10);
    check("pause_hold_count", 32'(count), 3);
    check("pause_no_tick", 32'(tick), 0);
    press_btn(0);
    check("resume_state", 32'(state), 1);
    cyc(4);
    check("resume_no_tick", 32'(tick), 0);
    cyc(1);
    check("resume_tick", 32'(tick), 1);
    check("resume_count", 32'(count), 2);

    // sw2 together with tick-to-zero: ALARM wins.
    cyc(1);
    press_btn(0);
    check("prio_alarm_state", 32'(state), 3);
    check("prio_alarm_count", 32'(count), 0);
    press_btn(2);
    check("clear_alarm", 32'(state), 0);

    // sw4 together with a tick at count 4: IDLE, count 0, no tick.
    dip = 10'd5;
    press_btn(1);
    press_btn(0);
    cyc(1);
    press_btn(2);
    check("prio_clear_state", 32'(state), 0);
    check("prio_clear_count", 32'(count), 0);
    check("prio_clear_tick", 32'(tick), 0);

    // Reset in the middle of a countdown.
    dip = 10'd7;
    press_btn(1);
    press_btn(0);
    check("run7_count", 32'(count), 7);
    cyc(3);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    check("midrun_rst_state", 32'(state), 0);
    check("midrun_rst_count", 32'(count), 0);

    // Reset one edge before a debounced press would fire.
    cyc(7);
    btn[3] = 1'b0;
    cyc(6);
    rst = 1'b1;
    btn[3] = 1'b1;
    cyc(1);
    rst = 1'b0;
    cyc(10);
    check("no_press_after_rst", 32'(count), 0);

    // ALARM with no button: auto-clear only when the timeout is built in.
    dip = 10'd1;
    press_btn(1);
    press_btn(0);
    cyc(8);
    check("alarm2_state", 32'(state), 3);
    check("alarm2_tick", 32'(tick), 1);
    cyc(8);
    check("alarm_no_tick", 32'(tick), 0);
    cyc(71);
    check("alarm_before_timeout", 32'(state), 3);
    cyc(1);
`ifdef TIMER_ALARM_TIMEOUT_EN
    check("alarm_timeout", 32'(state), 0);
`else
    check("alarm_no_timeout", 32'(state), 3);
`endif
    check("alarm_count_zero", 32'(count), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
